// File: rtl/switch_debounce.sv
// Four-bit DIP-switch synchronizer and debouncer with a change pulse.
// Define SWITCH_DEBOUNCE_EDGE_EN to add per-bit rise/fall pulse outputs.
module switch_debounce #(
    parameter int unsigned STABLE_CYCLES = 240000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] s,
    output logic [3:0] s_db,
    output logic       changed
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    ,
    output logic [3:0] rise,
    output logic [3:0] fall
`endif
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] TERM = CW'(STABLE_CYCLES - 1);

    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [CW-1:0] cnt     [4];
    logic [CW-1:0] cnt_nxt [4];
    logic [3:0]    load;

    // Each bit counts its own run of mismatches; terminal count loads s_db.
    always_comb begin
        load = '0;
        for (int i = 0; i < 4; i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != s_db[i]) begin
                if (cnt[i] == TERM) begin
                    load[i] = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            s_db    <= '0;
            changed <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1   <= s;
            sync2   <= sync1;
            s_db    <= s_db ^ load;
            changed <= |load;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rise <= '0;
            fall <= '0;
        end else begin
            rise <= load & sync2;
            fall <= load & ~sync2;
        end
    end
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: directed scenarios plus random switch activity
// compared every cycle against a sample-history reference model.
module tb_switch_debounce;

    localparam int SC = 4;
    localparam int HN = SC + 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] s = 4'h0;
    logic [3:0] s_db;
    logic       changed;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    logic [3:0] rise;
    logic [3:0] fall;
`endif

    int checks = 0;
    int errors = 0;

    // hist[k] is the value of s sampled k edges ago
    logic [3:0] hist [HN];
    logic [3:0] m_db = 4'h0;
    logic [3:0] m_rise = 4'h0;
    logic [3:0] m_fall = 4'h0;
    logic       m_chg = 1'b0;

    always #5 clk = ~clk;

    switch_debounce #(.STABLE_CYCLES(SC)) dut (
        .clk     (clk),
        .reset   (reset),
        .s       (s),
        .s_db    (s_db),
        .changed (changed)
`ifdef SWITCH_DEBOUNCE_EDGE_EN
        ,
        .rise    (rise),
        .fall    (fall)
`endif
    );

    task automatic chk(string tag, logic [3:0] got, logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // A bit flips once the SC samples seen by the filter all disagree with it.
    task automatic model_edge();
        logic [3:0] flip;
        if (reset) begin
            for (int i = 0; i < HN; i++) hist[i] = 4'h0;
            m_db   = 4'h0;
            m_chg  = 1'b0;
            m_rise = 4'h0;
            m_fall = 4'h0;
        end else begin
            for (int i = HN - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = s;
            flip = 4'hf;
            for (int j = 2; j < HN; j++) flip &= hist[j] ^ m_db;
            m_rise = flip & ~m_db;
            m_fall = flip & m_db;
            m_db   = m_db ^ flip;
            m_chg  = |flip;
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            chk("s_db", s_db, m_db);
            chk("changed", {3'b0, changed}, {3'b0, m_chg});
`ifdef SWITCH_DEBOUNCE_EDGE_EN
            chk("rise", rise, m_rise);
            chk("fall", fall, m_fall);
            chk("rf_or", {3'b0, |(rise | fall)}, {3'b0, changed});
            chk("rf_excl", rise & fall, 4'h0);
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < HN; i++) hist[i] = 4'h0;

        reset = 1'b1;
        s = 4'h0;
        tick(3);
        chk("rst_db", s_db, 4'h0);
        chk("rst_chg", {3'b0, changed}, 4'h0);
        reset = 1'b0;
        tick(50);
        chk("idle_db", s_db, 4'h0);

        s = 4'b0001;
        tick(5);
        chk("e5_db", s_db, 4'h0);
        tick(1);
        chk("e6_db", s_db, 4'b0001);
        chk("e6_chg", {3'b0, changed}, 4'h1);
`ifdef SWITCH_DEBOUNCE_EDGE_EN
        chk("e6_rise", rise, 4'b0001);
`endif
        tick(1);
        chk("e7_chg", {3'b0, changed}, 4'h0);

        repeat (5) begin
            s = 4'b0011;
            tick(3);
            s = 4'b0001;
            tick(3);
        end
        chk("bounce_db", s_db, 4'b0001);

        s = 4'b0000;
        tick(10);
        chk("clr_db", s_db, 4'h0);

        s = 4'b1111;
        tick(5);
        chk("all_pre", s_db, 4'h0);
        tick(1);
        chk("all_db", s_db, 4'hf);
        chk("all_chg", {3'b0, changed}, 4'h1);
`ifdef SWITCH_DEBOUNCE_EDGE_EN
        chk("all_rise", rise, 4'hf);
        chk("all_fall", fall, 4'h0);
`endif
        tick(4);
        s = 4'b0101;
        tick(6);
        chk("mix_db", s_db, 4'b0101);
`ifdef SWITCH_DEBOUNCE_EDGE_EN
        chk("mix_fall", fall, 4'b1010);
`endif

        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        s = 4'b0100;
        tick(2);
        reset = 1'b1;
        tick(2);
        chk("abort_db", s_db, 4'h0);
        reset = 1'b0;
        tick(5);
        chk("post_pre", s_db, 4'h0);
        tick(1);
        chk("post_db", s_db, 4'b0100);
        chk("post_chg", {3'b0, changed}, 4'h1);

        repeat (600) begin
            if ($urandom_range(0, 3) == 0) s = 4'($urandom);
            reset = ($urandom_range(0, 99) == 0);
            tick(1);
        end
        reset = 1'b0;
        tick(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
